hqc_rsencod_lfsr: RTL and testbench

Systematic Reed-Solomon encoder over GF(2^8) for HQC; the encode-side counterpart of the RS decoding chain in decap. Accepts a K-byte message in parallel and runs a byte-serial LFSR division by the generator polynomial g(x). Presents the N1-byte codeword (parity then message) in parallel to the Reed-Muller concatenation stage in encap. One message byte is consumed per cycle; the parity taps use 2·DELTA parallel combinational `gfmul` instances.

---
 rtl/hqc_rsencod_lfsr.sv | 167 ++++++++++++++++
 tb/tb_hqc_rsencod_lfsr.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hqc_rsencod_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : hqc_rsencod_lfsr
// Purpose  : Systematic Reed-Solomon encoder over GF(2^8) (field polynomial
//            0x11D) for HQC. A K-byte message is captured in parallel, then
//            divided byte-serially by the generator polynomial g(x) in an LFSR.
//            The N1-byte codeword (parity then message) is presented in
//            parallel.
// Ports    : clk_i        - clock, rising edge
//            rst_ni       - synchronous active-low reset
//            start_i      - one-cycle start pulse, ignored while busy_o=1
//            msg_i        - message, byte m[i] at bits [8i+7:8i]
//            busy_o       - encoding in progress
//            dout_o       - codeword {msg, parity}; parity byte j at [8j+7:8j]
//            dout_valid_o - one-cycle pulse, codeword complete
// Config   : HQC_RSENC_2BPC_EN - when defined, two message bytes are consumed
//            per cycle (two unrolled LFSR steps); latency K/2+1 instead of K+1.
// Revision : 1.0 - initial release
// ============================================================================
module hqc_rsencod_lfsr #(
  parameter int PARAM_SECURITY = 128,
  parameter int PARAM_K        = (PARAM_SECURITY == 256) ? 32 :
                                 (PARAM_SECURITY == 192) ? 24 : 16,
  parameter int PARAM_N1       = (PARAM_SECURITY == 256) ? 90 :
                                 (PARAM_SECURITY == 192) ? 56 : 46,
  parameter int PARAM_DELTA    = (PARAM_SECURITY == 256) ? 29 :
                                 (PARAM_SECURITY == 192) ? 16 : 15,
  parameter int MSG_W          = 8 * PARAM_K,
  parameter int DOUT_W         = 8 * PARAM_N1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [MSG_W-1:0]  msg_i,
  output logic              busy_o,
  output logic [DOUT_W-1:0] dout_o,
  output logic              dout_valid_o
);

  localparam int P  = 2 * PARAM_DELTA;
  localparam int PW = 8 * P;

`ifdef HQC_RSENC_2BPC_EN
  localparam int BPC = 2;
`else
  localparam int BPC = 1;
`endif

  localparam logic [5:0] LAST_CNT = 6'(PARAM_K / BPC - 1);

  // GF(2^8) multiply, field polynomial x^8+x^4+x^3+x^2+1 (0x11D).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] prod;
    logic [7:0] aa;
    prod = 8'h00;
    aa   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
    end
    return prod;
  endfunction

  // g(x) = prod_{i=1..P} (x + alpha^i), alpha = 0x02. Evaluated at elaboration,
  // this yields the HQC generator table for the selected level. The monic
  // x^P term is dropped; coefficient g[j] sits at bits [8j+7:8j].
  function automatic logic [PW-1:0] gen_poly();
    logic [8*(P+1)-1:0] acc;
    logic [7:0]         root;
    acc      = '0;
    acc[7:0] = 8'h01;
    root     = 8'h01;
    for (int i = 1; i <= P; i++) begin
      root = gf_mul(root, 8'h02);
      for (int j = P; j >= 1; j--) begin
        acc[8*j +: 8] = acc[8*(j-1) +: 8] ^ gf_mul(root, acc[8*j +: 8]);
      end
      acc[7:0] = gf_mul(root, acc[7:0]);
    end
    return acc[PW-1:0];
  endfunction

  localparam logic [PW-1:0] G = gen_poly();

  // One LFSR division step: feedback is the incoming byte XOR the top parity
  // byte; every tap is a constant multiply, i.e. P parallel XOR networks.
  function automatic logic [PW-1:0] lfsr_step(input logic [PW-1:0] par,
                                              input logic [7:0]    din);
    logic [7:0]    fb;
    logic [PW-1:0] nxt;
    fb       = din ^ par[PW-1 -: 8];
    nxt      = '0;
    nxt[7:0] = gf_mul(fb, G[7:0]);
    for (int j = 1; j < P; j++) begin
      nxt[8*j +: 8] = par[8*(j-1) +: 8] ^ gf_mul(fb, G[8*j +: 8]);
    end
    return nxt;
  endfunction

  logic              busy_q,  busy_d;
  logic              valid_q, valid_d;
  logic [5:0]        cnt_q,   cnt_d;
  logic [MSG_W-1:0]  msg_q,   msg_d;
  logic [PW-1:0]     par_q,   par_d;

  logic [PW-1:0]     w_step1;
  logic [PW-1:0]     w_step;
  logic [MSG_W-1:0]  w_msg_rot;
  logic              w_busy_end;

  // Highest message byte enters first; rotating the buffer brings the next
  // byte to the top and restores the original message after all K bytes.
  assign w_step1 = lfsr_step(par_q, msg_q[MSG_W-1 -: 8]);
`ifdef HQC_RSENC_2BPC_EN
  assign w_step    = lfsr_step(w_step1, msg_q[MSG_W-9 -: 8]);
  assign w_msg_rot = {msg_q[MSG_W-17:0], msg_q[MSG_W-1 -: 16]};
`else
  assign w_step    = w_step1;
  assign w_msg_rot = {msg_q[MSG_W-9:0], msg_q[MSG_W-1 -: 8]};
`endif

  assign w_busy_end = busy_q && (cnt_q == LAST_CNT);

  always_comb begin
    busy_d  = busy_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    par_d   = par_q;
    if (busy_q) begin
      par_d = w_step;
      msg_d = w_msg_rot;
      cnt_d = cnt_q + 6'd1;
      if (w_busy_end) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = 6'd0;
      msg_d  = msg_i;
      par_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= 6'd0;
      msg_q   <= '0;
      par_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
      par_q   <= par_d;
    end
  end

  assign busy_o       = busy_q;
  assign dout_valid_o = valid_q;
  assign dout_o       = {msg_q, par_q};

endmodule
`default_nettype wire

// File: tb/tb_hqc_rsencod_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : tb_hqc_rsencod_lfsr
// Purpose  : Self-checking bench for hqc_rsencod_lfsr at all three security
//            levels. Expected codewords come from polynomial long division of
//            m(x)*x^P by g(x), with g(x) built from its roots using log/antilog
//            GF(2^8) arithmetic. Honours HQC_RSENC_2BPC_EN for latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hqc_rsencod_lfsr;

`ifdef HQC_RSENC_2BPC_EN
  localparam int BPC = 2;
`else
  localparam int BPC = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start [3];
  logic [255:0] msg   [3];
  logic         busy  [3];
  logic         valid [3];
  logic [367:0] dout0;
  logic [447:0] dout1;
  logic [719:0] dout2;

  int n_pass  = 0;
  int n_total = 0;

  int gexp [0:509];
  int glog [0:255];
  int gp   [3][0:58];

  always #5 clk = ~clk;

  hqc_rsencod_lfsr #(.PARAM_SECURITY(128)) u_dut128 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .msg_i(msg[0][127:0]),
    .busy_o(busy[0]), .dout_o(dout0), .dout_valid_o(valid[0]));
  hqc_rsencod_lfsr #(.PARAM_SECURITY(192)) u_dut192 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .msg_i(msg[1][191:0]),
    .busy_o(busy[1]), .dout_o(dout1), .dout_valid_o(valid[1]));
  hqc_rsencod_lfsr #(.PARAM_SECURITY(256)) u_dut256 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .msg_i(msg[2]),
    .busy_o(busy[2]), .dout_o(dout2), .dout_valid_o(valid[2]));

  function automatic int kval(input int l);
    return (l == 0) ? 16 : (l == 1) ? 24 : 32;
  endfunction

  function automatic int pval(input int l);
    return (l == 0) ? 30 : (l == 1) ? 32 : 58;
  endfunction

  function automatic int lat_exp(input int l);
    return kval(l) / BPC + 1;
  endfunction

  function automatic logic [719:0] dout_of(input int l);
    if (l == 0) return {352'b0, dout0};
    if (l == 1) return {272'b0, dout1};
    return dout2;
  endfunction

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[glog[a] + glog[b]];
  endfunction

  task automatic init_field();
    int v;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i]       = v;
      gexp[i + 255] = v;
      glog[v]       = i;
      v = v << 1;
      if ((v & 256) != 0) v = v ^ 285;
    end
    glog[0] = 0;
    for (int l = 0; l < 3; l++) begin
      for (int j = 0; j <= 58; j++) gp[l][j] = 0;
      gp[l][0] = 1;
      for (int i = 1; i <= pval(l); i++) begin
        for (int j = i; j >= 0; j--)
          gp[l][j] = ((j > 0) ? gp[l][j-1] : 0) ^ gmul(gexp[i], gp[l][j]);
      end
    end
  endtask

  // Reference codeword: remainder of m(x)*x^P divided by g(x), followed by m.
  function automatic logic [719:0] ref_cw(input int l, input logic [255:0] m);
    int k;
    int p;
    int c;
    int r [0:89];
    logic [719:0] cw;
    k  = kval(l);
    p  = pval(l);
    cw = '0;
    for (int i = 0; i < 90; i++) r[i] = 0;
    for (int i = 0; i < k; i++) r[p + i] = int'(m[8*i +: 8]);
    for (int d = k + p - 1; d >= p; d--) begin
      c = r[d];
      if (c != 0)
        for (int j = 0; j <= p; j++) r[d - p + j] = r[d - p + j] ^ gmul(c, gp[l][j]);
    end
    for (int i = 0; i < p; i++) cw[8*i +: 8] = 8'(r[i]);
    for (int i = 0; i < k; i++) cw[8*(p + i) +: 8] = m[8*i +: 8];
    return cw;
  endfunction

  function automatic logic [255:0] rand_msg(input int l);
    logic [255:0] m;
    logic [255:0] mask;
    for (int w = 0; w < 8; w++) m[32*w +: 32] = $urandom;
    mask = '0;
    for (int i = 0; i < 8 * kval(l); i++) mask[i] = 1'b1;
    return m & mask;
  endfunction

  // Starts an encode at the current negedge and watches a fixed window.
  // Optional extra start pulses (with a different message) at cycles e1/e2.
  task automatic do_encode(input int l, input logic [255:0] m, input int e1, input int e2,
                           output int lat, output int nval, output logic [719:0] cw,
                           output logic busy_at_valid);
    msg[l]   = m;
    start[l] = 1'b1;
    lat = -1; nval = 0; cw = '0; busy_at_valid = 1'b1;
    for (int c = 1; c <= lat_exp(l) + 3; c++) begin
      @(negedge clk);
      start[l] = (c == e1 || c == e2);
      if (start[l]) msg[l] = ~m;
      if (valid[l]) begin
        nval++;
        if (lat < 0) begin
          lat = c; cw = dout_of(l); busy_at_valid = busy[l];
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      n_total++;
      if (busy[l] !== 1'b0) $display("FAIL reset_busy lvl%0d got %b want 0", l, busy[l]);
      else n_pass++;
      n_total++;
      if (valid[l] !== 1'b0) $display("FAIL reset_valid lvl%0d got %b want 0", l, valid[l]);
      else n_pass++;
      n_total++;
      if (dout_of(l) !== '0) $display("FAIL reset_dout lvl%0d got %h want 0", l, dout_of(l));
      else n_pass++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed(input bit unit);
    int lat; int nv; logic [719:0] cw; logic bav; logic [255:0] m;
    for (int l = 0; l < 3; l++) begin
      m = unit ? 256'h1 : 256'h0;
      do_encode(l, m, 0, 0, lat, nv, cw, bav);
      n_total++;
      if (lat !== lat_exp(l) || nv !== 1)
        $display("FAIL fixed%0d_latency lvl%0d got lat=%0d nval=%0d want lat=%0d nval=1", unit, l, lat, nv, lat_exp(l));
      else n_pass++;
      n_total++;
      if (cw !== ref_cw(l, m)) $display("FAIL fixed%0d_dout lvl%0d got %h want %h", unit, l, cw, ref_cw(l, m));
      else n_pass++;
      n_total++;
      if (bav !== 1'b0) $display("FAIL fixed%0d_busy_at_valid lvl%0d got %b want 0", unit, l, bav);
      else n_pass++;
      if (unit) begin
        // x^P mod g(x) is g(x) minus its leading term: parity must equal g.
        for (int j = 0; j < pval(l); j++) begin
          n_total++;
          if (cw[8*j +: 8] !== 8'(gp[l][j]))
            $display("FAIL unit_parity lvl%0d byte%0d got %h want %h", l, j, cw[8*j +: 8], 8'(gp[l][j]));
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_random();
    int lat; int nv; logic [719:0] cw; logic bav; logic [255:0] m;
    for (int l = 0; l < 3; l++) begin
      for (int t = 0; t < 4; t++) begin
        m = rand_msg(l);
        do_encode(l, m, 0, 0, lat, nv, cw, bav);
        n_total++;
        if (cw !== ref_cw(l, m)) $display("FAIL random_dout lvl%0d got %h want %h", l, cw, ref_cw(l, m));
        else n_pass++;
        n_total++;
        if (lat !== lat_exp(l) || nv !== 1)
          $display("FAIL random_latency lvl%0d got lat=%0d nval=%0d want %0d/1", l, lat, nv, lat_exp(l));
        else n_pass++;
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat; int nv; logic [719:0] cw; logic bav; logic [255:0] m;
    for (int l = 0; l < 3; l++) begin
      m = rand_msg(l);
      // second pulse lands in the last busy cycle
      do_encode(l, m, 3, kval(l) / BPC, lat, nv, cw, bav);
      n_total++;
      if (nv !== 1 || lat !== lat_exp(l))
        $display("FAIL busy_ignore_valids lvl%0d got nval=%0d lat=%0d want 1/%0d", l, nv, lat, lat_exp(l));
      else n_pass++;
      n_total++;
      if (cw !== ref_cw(l, m)) $display("FAIL busy_ignore_dout lvl%0d got %h want %h", l, cw, ref_cw(l, m));
      else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    int lat; int nv; logic [719:0] cw; logic bav; logic [255:0] m;
    for (int l = 0; l < 3; l++) begin
      msg[l]   = rand_msg(l);
      start[l] = 1'b1;
      @(negedge clk);
      start[l] = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_total++;
      if (busy[l] !== 1'b0 || valid[l] !== 1'b0 || dout_of(l) !== '0)
        $display("FAIL abort_outputs lvl%0d got busy=%b valid=%b dout=%h want all 0", l, busy[l], valid[l], dout_of(l));
      else n_pass++;
      nv = 0;
      for (int c = 0; c < lat_exp(l) + 2; c++) begin
        @(negedge clk);
        if (valid[l]) nv++;
      end
      n_total++;
      if (nv !== 0) $display("FAIL abort_no_valid lvl%0d got %0d pulses want 0", l, nv);
      else n_pass++;
      m = rand_msg(l);
      do_encode(l, m, 0, 0, lat, nv, cw, bav);
      n_total++;
      if (cw !== ref_cw(l, m) || lat !== lat_exp(l))
        $display("FAIL abort_restart lvl%0d got lat=%0d dout=%h want lat=%0d dout=%h", l, lat, cw, lat_exp(l), ref_cw(l, m));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] m1; logic [255:0] m2; logic [719:0] cw1; logic [719:0] cw2;
    int nv; int t1; int t2;
    for (int l = 0; l < 3; l++) begin
      m1 = rand_msg(l); m2 = rand_msg(l);
      nv = 0; t1 = -1; t2 = -1; cw1 = '0; cw2 = '0;
      msg[l] = m1; start[l] = 1'b1;
      for (int c = 1; c <= 2 * lat_exp(l) + 3; c++) begin
        @(negedge clk);
        start[l] = 1'b0;
        if (valid[l]) begin
          nv++;
          if (nv == 1) begin
            t1 = c; cw1 = dout_of(l); msg[l] = m2; start[l] = 1'b1;
          end else if (nv == 2) begin
            t2 = c; cw2 = dout_of(l);
          end
        end
      end
      n_total++;
      if (cw1 !== ref_cw(l, m1)) $display("FAIL b2b_first lvl%0d got %h want %h", l, cw1, ref_cw(l, m1));
      else n_pass++;
      n_total++;
      if (cw2 !== ref_cw(l, m2)) $display("FAIL b2b_second lvl%0d got %h want %h", l, cw2, ref_cw(l, m2));
      else n_pass++;
      n_total++;
      if (nv !== 2 || t1 !== lat_exp(l) || (t2 - t1) !== lat_exp(l))
        $display("FAIL b2b_timing lvl%0d got nval=%0d t1=%0d gap=%0d want 2/%0d/%0d", l, nv, t1, t2 - t1, lat_exp(l), lat_exp(l));
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int l = 0; l < 3; l++) begin
      start[l] = 1'b0;
      msg[l]   = '0;
    end
    init_field();
    @(negedge clk);
    test_reset();
    test_fixed(1'b0);
    test_fixed(1'b1);
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
